// File: rtl/counter2_sched_if.sv
// Bus between the counter2 scheduler, its requesters and the counter2 instance it drives.
// The master side holds requests and returns cnt_eq; the slave side is the scheduler.
interface counter2_sched_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] req_len;
  logic [N-1:0]       gnt;
  logic [N-1:0]       done;
  logic               busy;
  logic               cnt_clr;
  logic               cnt_en;
  logic [WIDTH-1:0]   cnt_max;
  logic               cnt_eq;

  modport master (
    output req, req_len, cnt_eq,
    input  gnt, done, busy, cnt_clr, cnt_en, cnt_max
  );

  modport slave (
    input  req, req_len, cnt_eq,
    output gnt, done, busy, cnt_clr, cnt_en, cnt_max
  );
endinterface

// File: rtl/counter2_sched.sv
// Round-robin scheduler that time-shares one counter2 among N requesters,
// loading max_val, sequencing clr/en and pulsing done to the owner on eq.
module counter2_sched #(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst_n,
  counter2_sched_if.slave bus
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       r_state;
  logic [PTR_W-1:0] r_ptr;
  logic [N-1:0]     r_gnt;
  logic [N-1:0]     r_done;
  logic [WIDTH-1:0] r_cnt_max;

  logic             w_found;
  logic [PTR_W-1:0] w_winner;
  logic [PTR_W-1:0] w_ptr_next;
  logic             w_owner_req;

  // Circular search for the first set request at or after the rr pointer.
  always_comb begin
    int idx;
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_found  = 1'b0;
    w_winner = '0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!w_found && bus.req[idx]) begin
        w_found  = 1'b1;
        w_winner = PTR_W'(idx);
      end
    end
  end

  assign w_ptr_next  = (w_winner == PTR_W'(N - 1)) ? '0 : w_winner + PTR_W'(1);
  assign w_owner_req = |(bus.req & r_gnt);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_cnt_max <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state   <= S_CLEAR;
            r_gnt     <= N'(1) << w_winner;
            r_cnt_max <= bus.req_len[w_winner*WIDTH +: WIDTH];
            r_ptr     <= w_ptr_next;
          end
        end
        S_CLEAR: begin
          if (!w_owner_req) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // A dropped request abandons the count even if eq fires in the same cycle.
          if (!w_owner_req) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
          end else if (bus.cnt_eq) begin
            r_state <= S_DONE;
            r_done  <= r_gnt;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.done    = r_done;
  assign bus.cnt_max = r_cnt_max;
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.cnt_clr = (r_state == S_CLEAR);
  // en drops at eq so the counter parks on max_val, even for the all-ones value.
  assign bus.cnt_en  = (r_state == S_RUN) && !bus.cnt_eq;

endmodule

// File: tb/tb_counter2_sched.sv
// Directed bench for counter2_sched with a behavioural counter2 beside it;
// cycle k means k rising edges after the edge that sampled the request.
module tb_counter2_sched;

  localparam int N     = 4;
  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  logic [WIDTH-1:0] cnt;

  int total;
  int bad;

  counter2_sched_if #(.N(N), .WIDTH(WIDTH)) bus ();

  counter2_sched #(.N(N), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // counter2: synchronous clear, count on en, eq compares combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (bus.cnt_clr) cnt <= '0;
    else if (bus.cnt_en)  cnt <= cnt + WIDTH'(1);
  end
  assign bus.cnt_eq = (cnt == bus.cnt_max);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    int en_cycles;
    int g_start [5];
    int g_end   [5];
    int g_own   [5];
    logic [N-1:0] exp_g;
    logic [N-1:0] exp_d;

    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    bus.req = '0;
    bus.req_len = '0;

    // Reset state
    step(2);
    check("rst_gnt", bus.gnt, 0);
    check("rst_done", bus.done, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_max", bus.cnt_max, 0);
    check("rst_clr", bus.cnt_clr, 0);
    check("rst_en", bus.cnt_en, 0);
    rst_n = 1'b1;
    step();
    check("idle_busy", bus.busy, 0);

    // Single request, length 5
    bus.req_len = 32'h0000_0005;
    bus.req     = 4'b0001;
    step();
    check("t1_gnt_c1", bus.gnt, 4'b0001);
    check("t1_clr_c1", bus.cnt_clr, 1);
    check("t1_en_c1", bus.cnt_en, 0);
    check("t1_max_c1", bus.cnt_max, 5);
    check("t1_busy_c1", bus.busy, 1);
    en_cycles = 0;
    for (int c = 2; c <= 7; c++) begin
      step();
      if (bus.cnt_en) en_cycles++;
    end
    check("t1_en_cycles", en_cycles, 5);
    check("t1_cnt_c7", cnt, 5);
    check("t1_done_c7", bus.done, 0);
    step();
    check("t1_done_c8", bus.done, 4'b0001);
    check("t1_gnt_c8", bus.gnt, 4'b0001);
    bus.req = '0;
    step();
    check("t1_busy_c9", bus.busy, 0);
    check("t1_gnt_c9", bus.gnt, 0);
    check("t1_done_c9", bus.done, 0);

    // Zero length
    bus.req_len = 32'h0000_0000;
    bus.req     = 4'b0001;
    step();
    check("t2_clr_c1", bus.cnt_clr, 1);
    check("t2_gnt_c1", bus.gnt, 4'b0001);
    step();
    check("t2_clr_c2", bus.cnt_clr, 0);
    check("t2_en_c2", bus.cnt_en, 0);
    check("t2_busy_c2", bus.busy, 1);
    check("t2_done_c2", bus.done, 0);
    step();
    check("t2_done_c3", bus.done, 4'b0001);
    bus.req = '0;
    step();
    check("t2_busy_c4", bus.busy, 0);

    // Round-robin with all four held, lengths 1..4, from a fresh pointer
    pulse_reset();
    g_start = '{1, 6, 12, 19, 27};
    g_end   = '{4, 10, 17, 25, 30};
    g_own   = '{0, 1, 2, 3, 0};
    bus.req_len = 32'h0403_0201;
    bus.req     = 4'b1111;
    for (int c = 1; c <= 30; c++) begin
      step();
      exp_g = '0;
      exp_d = '0;
      for (int k = 0; k < 5; k++) begin
        if (c >= g_start[k] && c <= g_end[k]) exp_g = N'(1) << g_own[k];
        if (c == g_end[k])                    exp_d = N'(1) << g_own[k];
      end
      check($sformatf("rr_gnt_c%0d", c), bus.gnt, exp_g);
      check($sformatf("rr_done_c%0d", c), bus.done, exp_d);
    end
    bus.req = '0;
    step();
    check("rr_gnt_c31", bus.gnt, 0);
    check("rr_busy_c31", bus.busy, 0);

    // Abort: owner 0 drops in cycle 6 while requester 2 waits
    bus.req_len = 32'h0002_0014;
    bus.req     = 4'b0001;
    step();
    check("ab_gnt_c1", bus.gnt, 4'b0001);
    bus.req = 4'b0101;
    step(4);
    check("ab_gnt_c5", bus.gnt, 4'b0001);
    step();
    bus.req = 4'b0100;
    step();
    check("ab_gnt_c7", bus.gnt, 0);
    check("ab_done_c7", bus.done, 0);
    check("ab_busy_c7", bus.busy, 0);
    step();
    check("ab_gnt_c8", bus.gnt, 4'b0100);
    check("ab_clr_c8", bus.cnt_clr, 1);
    check("ab_max_c8", bus.cnt_max, 2);
    check("ab_cnt_c8", cnt, 5);
    step();
    check("ab_cnt_c9", cnt, 0);
    check("ab_en_c9", bus.cnt_en, 1);
    step(3);
    check("ab_done_c12", bus.done, 4'b0100);
    bus.req = '0;
    step();
    check("ab_busy_c13", bus.busy, 0);

    // Max length, req_len changed mid-run
    bus.req_len = 32'h0000_00FF;
    bus.req     = 4'b0001;
    step();
    check("mx_gnt_c1", bus.gnt, 4'b0001);
    check("mx_max_c1", bus.cnt_max, 8'hFF);
    step(2);
    bus.req_len = 32'h0303_0303;
    step(47);
    check("mx_max_c50", bus.cnt_max, 8'hFF);
    check("mx_cnt_c50", cnt, 48);
    check("mx_en_c50", bus.cnt_en, 1);
    step(207);
    check("mx_cnt_c257", cnt, 8'hFF);
    check("mx_en_c257", bus.cnt_en, 0);
    check("mx_done_c257", bus.done, 0);
    step();
    check("mx_done_c258", bus.done, 4'b0001);
    check("mx_cnt_c258", cnt, 8'hFF);
    bus.req = '0;
    step();
    check("mx_busy_c259", bus.busy, 0);
    check("mx_cnt_c259", cnt, 8'hFF);
    check("mx_max_c259", bus.cnt_max, 8'hFF);

    // Asynchronous reset in the middle of a run
    bus.req_len = 32'h0000_0A00;
    bus.req     = 4'b0010;
    step();
    check("ar_gnt_c1", bus.gnt, 4'b0010);
    step(2);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_gnt", bus.gnt, 0);
    check("ar_done", bus.done, 0);
    check("ar_busy", bus.busy, 0);
    check("ar_max", bus.cnt_max, 0);
    check("ar_clr", bus.cnt_clr, 0);
    check("ar_en", bus.cnt_en, 0);
    check("ar_cnt", cnt, 0);
    #1;
    rst_n       = 1'b1;
    bus.req_len = 32'h0101_0101;
    bus.req     = 4'b1111;
    step();
    check("ar_regnt_c1", bus.gnt, 4'b0001);
    bus.req = '0;
    step(2);
    check("ar_end_busy", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
